// File: rtl/hdr_stream_pkg.sv
// hdr_stream_pkg: shared definitions for the header-prepend stream path.
//  - default geometry (phit width, lane width, header lanes)
//  - state_e : re-wrapper FSM states
//  - csum16  : end-around-carry fold of a 20-bit partial sum to 16 bits
package hdr_stream_pkg;

  localparam int P_PHIT_BITS = 512;
  localparam int P_LANE_BITS = 16;
  localparam int P_HDR_LANES = 17;
  localparam int P_SUM_W     = 20;  // wide enough for up to 16 summed 16-bit words

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CSUM,
    ST_HEAD,
    ST_BODY,
    ST_TAIL
  } state_e;

  // Two folds suffice for 20 bits: the first leaves at most 0x1000E,
  // and the second cannot carry again.
  function automatic logic [15:0] csum16(input logic [P_SUM_W-1:0] s);
    logic [16:0] t;
    t = {1'b0, s[15:0]} + {13'd0, s[P_SUM_W-1:16]};
    return t[15:0] + {15'd0, t[16]};
  endfunction

endpackage

// File: rtl/ones_comp_csum.sv
// ones_comp_csum: pipelined 16-bit one's-complement checksum.
//  Registered pairwise adder tree (20-bit intermediates) followed by a
//  registered fold + invert. Latency = $clog2(WORDS) + 2 cycles.
// Ports:
//  clk   in  1          clock
//  win   in  WORDS*16   words to sum, word 0 = bits [15:0]
//  csum  out 16         ~folded sum
module ones_comp_csum
  import hdr_stream_pkg::*;
#(
  parameter int WORDS = 10
) (
  input  logic              clk,
  input  logic [WORDS*16-1:0] win,
  output logic [15:0]       csum
);

  localparam int LVLS   = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int LEAVES = 1 << LVLS;
  localparam int NODES  = 2*LEAVES - 1;

  // Heap layout: node i has children 2i+1, 2i+2; leaves start at LEAVES-1.
  // Every node is a flop, so all leaves sit at the same pipeline depth.
  logic [P_SUM_W-1:0] node [NODES];

  for (genvar i = 0; i < NODES; i++) begin : g_node
    if (i >= LEAVES-1) begin : g_leaf
      if (i - (LEAVES-1) < WORDS) begin : g_word
        always_ff @(posedge clk) node[i] <= {4'd0, win[(i-(LEAVES-1))*16 +: 16]};
      end else begin : g_pad
        always_ff @(posedge clk) node[i] <= '0;
      end
    end else begin : g_add
      always_ff @(posedge clk) node[i] <= node[2*i+1] + node[2*i+2];
    end
  end

  always_ff @(posedge clk) csum <= ~csum16(node[0]);

endmodule

// File: rtl/hdr_prepend_stream.sv
// hdr_prepend_stream: prepends a HDR_LANES-lane header to a payload stream.
//  Payload is lane-shifted up by HDR_LANES; the top HDR_LANES input lanes
//  carry into the bottom of the next output beat, with an extra tail beat
//  when the last input beat overflows. The header's length field is filled
//  from len_reg at header accept.
//  Build option HDR_CSUM_EN: recompute the 16-bit one's-complement checksum
//  field over [CSUM_LO_BIT, CSUM_HI_BIT); otherwise it passes through.
// Ports:
//  clk, rst (sync, active-low)
//  cfg_len/cfg_len_we            length value for subsequent headers
//  hdr_in/hdr_valid/hdr_ready    header template handshake (IDLE only)
//  s_tdata/tkeep/tlast/tvalid/tready   payload in
//  m_tdata/tkeep/tlast/tvalid/tready   wrapped stream out (registered)
module hdr_prepend_stream
  import hdr_stream_pkg::*;
#(
  parameter int PHIT_BITS   = P_PHIT_BITS,
  parameter int LANE_BITS   = P_LANE_BITS,
  parameter int HDR_LANES   = P_HDR_LANES,
  parameter int LEN_OFF     = 128,
  parameter int CSUM_OFF    = 192,
  parameter int CSUM_LO_BIT = 112,
  parameter int CSUM_HI_BIT = 272
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [15:0]                    cfg_len,
  input  logic                           cfg_len_we,
  input  logic [HDR_LANES*LANE_BITS-1:0] hdr_in,
  input  logic                           hdr_valid,
  output logic                           hdr_ready,
  input  logic [PHIT_BITS-1:0]           s_tdata,
  input  logic [PHIT_BITS/LANE_BITS-1:0] s_tkeep,
  input  logic                           s_tlast,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  output logic [PHIT_BITS-1:0]           m_tdata,
  output logic [PHIT_BITS/LANE_BITS-1:0] m_tkeep,
  output logic                           m_tlast,
  output logic                           m_tvalid,
  input  logic                           m_tready
);

  localparam int LANES    = PHIT_BITS / LANE_BITS;
  localparam int HDR_BITS = HDR_LANES * LANE_BITS;
  localparam int PL_LANES = LANES - HDR_LANES;
  localparam int PL_BITS  = PL_LANES * LANE_BITS;
  localparam int WIN_BITS = CSUM_HI_BIT - CSUM_LO_BIT;

`ifdef HDR_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif
  // Matches the adder-tree depth plus its input and fold registers.
  localparam int CSUM_LAT = CSUM_ON ? $clog2(WIN_BITS/16) + 2 : 1;

  state_e               state;
  logic [7:0]           cnt;
  logic [15:0]          len_reg;
  logic [HDR_BITS-1:0]  hdr_reg, hdr_next, hdr_out, carry_data;
  logic [HDR_LANES-1:0] carry_keep;
  logic [15:0]          csum_field;
  logic                 out_free, in_fire, ovf;

  assign hdr_ready = (state == ST_IDLE);
  assign out_free  = !m_tvalid || m_tready;
  assign s_tready  = ((state == ST_HEAD) || (state == ST_BODY)) && out_free;
  assign in_fire   = s_tvalid && s_tready;
  // Any kept lane in the carry region of a last beat needs a tail beat.
  assign ovf       = |s_tkeep[LANES-1:PL_LANES];

  always_comb begin
    hdr_next = hdr_in;
    hdr_next[LEN_OFF +: 16] = len_reg;
  end

`ifdef HDR_CSUM_EN
  logic [WIN_BITS-1:0] csum_win;
  logic [15:0]         csum_val;

  // The checksum field itself is summed as zero.
  always_comb begin
    csum_win = hdr_reg[CSUM_LO_BIT +: WIN_BITS];
    csum_win[CSUM_OFF-CSUM_LO_BIT +: 16] = '0;
  end

  ones_comp_csum #(.WORDS(WIN_BITS/16)) u_csum (
    .clk  (clk),
    .win  (csum_win),
    .csum (csum_val)
  );

  assign csum_field = csum_val;
`else
  assign csum_field = hdr_reg[CSUM_OFF +: 16];
`endif

  always_comb begin
    hdr_out = hdr_reg;
    hdr_out[CSUM_OFF +: 16] = csum_field;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      len_reg    <= '0;
      hdr_reg    <= '0;
      carry_data <= '0;
      carry_keep <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      m_tkeep    <= '0;
      m_tdata    <= '0;
    end else begin
      if (cfg_len_we) len_reg <= cfg_len;
      if (m_tvalid && m_tready) m_tvalid <= 1'b0;

      unique case (state)
        ST_IDLE: if (hdr_valid) begin
          hdr_reg <= hdr_next;
          cnt     <= '0;
          state   <= ST_CSUM;
        end
        ST_CSUM: begin
          if (cnt == 8'(CSUM_LAT-1)) state <= ST_HEAD;
          else                       cnt   <= cnt + 8'd1;
        end
        ST_HEAD, ST_BODY: if (in_fire) begin
          m_tvalid   <= 1'b1;
          m_tdata    <= {s_tdata[PL_BITS-1:0],
                         (state == ST_HEAD) ? hdr_out : carry_data};
          m_tkeep    <= {s_tkeep[PL_LANES-1:0],
                         (state == ST_HEAD) ? {HDR_LANES{1'b1}} : carry_keep};
          carry_data <= s_tdata[PHIT_BITS-1:PL_BITS];
          carry_keep <= s_tkeep[LANES-1:PL_LANES];
          m_tlast    <= s_tlast && !ovf;
          state      <= !s_tlast ? ST_BODY : (ovf ? ST_TAIL : ST_IDLE);
        end
        ST_TAIL: if (out_free) begin
          m_tvalid <= 1'b1;
          m_tdata  <= {{PL_BITS{1'b0}}, carry_data};
          m_tkeep  <= {{PL_LANES{1'b0}}, carry_keep};
          m_tlast  <= 1'b1;
          state    <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdr_prepend_stream.sv
// tb_hdr_prepend_stream: directed, table-driven check of hdr_prepend_stream
// at default geometry (32 lanes, 17-lane header). Output beats are compared
// against a flat lane-stream model of the wrapped packet.
module tb_hdr_prepend_stream;

  localparam int PB = 512, L = 32, HL = 17, HB = 272;

`ifdef HDR_CSUM_EN
  localparam logic [15:0] EXP_T4_FIELD = 16'hB861;
  localparam int          EXP_LAT      = 6;
`else
  localparam logic [15:0] EXP_T4_FIELD = 16'h1234;
  localparam int          EXP_LAT      = 1;
`endif

  logic          clk = 1'b0, rst = 1'b0;
  logic [15:0]   cfg_len = '0;
  logic          cfg_len_we = 1'b0;
  logic [HB-1:0] hdr_in = '0;
  logic          hdr_valid = 1'b0, hdr_ready;
  logic [PB-1:0] s_tdata = '0;
  logic [L-1:0]  s_tkeep = '0;
  logic          s_tlast = 1'b0, s_tvalid = 1'b0, s_tready;
  logic [PB-1:0] m_tdata;
  logic [L-1:0]  m_tkeep;
  logic          m_tlast, m_tvalid;
  logic          m_tready = 1'b1;

  hdr_prepend_stream dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .cfg_len_we(cfg_len_we),
    .hdr_in(hdr_in), .hdr_valid(hdr_valid), .hdr_ready(hdr_ready),
    .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .s_tvalid(s_tvalid), .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tlast(m_tlast),
    .m_tvalid(m_tvalid), .m_tready(m_tready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [PB-1:0] data; logic [L-1:0] keep; logic last; } beat_t;
  typedef struct { int nb; logic [L-1:0] lkeep; int exp_n; logic [L-1:0] exp_k; } vec_t;

  beat_t        outq[$];
  beat_t        held;
  logic [PB-1:0] pay [8];
  logic [L-1:0]  pk  [8];
  int  n_chk = 0, n_pass = 0;
  logic hdr_fire = 1'b0, in_fire = 1'b0, s_rdy_seen = 1'b0, prev_stall = 1'b0;

  task automatic chk(input string nm, input logic [575:0] act, input logic [575:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  task automatic fail_to(input string nm);
    n_chk++;
    $display("FAIL %s: timed out", nm);
  endtask

  function automatic logic [PB-1:0] rnd512();
    logic [PB-1:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [HB-1:0] rnd_hdr();
    logic [PB-1:0] r;
    r = rnd512();
    return r[HB-1:0];
  endfunction

  // Reference checksum: 32-bit accumulate, fold until it fits, invert.
  function automatic logic [15:0] ref_csum(input logic [HB-1:0] h);
    int unsigned s;
    s = 0;
    for (int i = 0; i < 10; i++)
      if (112 + 16*i != 192) s += 32'(h[112 + 16*i +: 16]);
    while (s > 32'hFFFF) s = (s & 32'hFFFF) + (s >> 16);
    return ~s[15:0];
  endfunction

  // Inputs are changed at the negedge; sample 1 ns later, then cross posedge.
  task automatic step();
    #1;
    hdr_fire   = hdr_valid && hdr_ready;
    in_fire    = s_tvalid && s_tready;
    s_rdy_seen = s_tready;
    if (rst && prev_stall)
      chk("hold", {m_tvalid, m_tlast, m_tkeep, m_tdata}, {1'b1, held.last, held.keep, held.data});
    prev_stall = rst && m_tvalid && !m_tready;
    if (prev_stall) held = '{m_tdata, m_tkeep, m_tlast};
    if (rst && m_tvalid && m_tready) outq.push_back('{m_tdata, m_tkeep, m_tlast});
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run_pkt(input string nm, input logic [HB-1:0] hdr, input int nb,
                         input logic [L-1:0] lkeep, input bit alt_rdy,
                         input logic [15:0] exp_len, input int len_wr_at,
                         input logic [15:0] len_wr_val,
                         output int nout, output logic [L-1:0] okeep, output int lat);
    logic [HB-1:0] eh;
    logic [15:0]   lanes[$];
    logic [PB-1:0] ed, mask;
    logic [L-1:0]  ek;
    int t, b, nexp;
    bit done;
    for (int i = 0; i < nb; i++) begin
      pay[i] = rnd512();
      pk[i]  = (i == nb-1) ? lkeep : '1;
    end
    outq.delete();
    lat = -1; nout = 0; okeep = '0;
    hdr_in = hdr; hdr_valid = 1'b1; m_tready = 1'b1;
    t = 0;
    do begin step(); t++; end while (!hdr_fire && t < 50);
    hdr_valid = 1'b0;
    if (!hdr_fire) begin fail_to({nm, " hdr"}); return; end
    b = 0; t = 0; done = 1'b0;
    while (!done && t < 200) begin
      m_tready   = alt_rdy ? (t % 2 == 0) : 1'b1;
      cfg_len    = len_wr_val;
      cfg_len_we = (t == len_wr_at);
      s_tvalid   = (b < nb);
      s_tdata    = (b < nb) ? pay[b] : '0;
      s_tkeep    = (b < nb) ? pk[b] : '0;
      s_tlast    = (b == nb-1);
      step();
      if (s_rdy_seen && lat < 0) lat = t;
      if (in_fire) b++;
      done = (outq.size() > 0) && outq[outq.size()-1].last;
      t++;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; cfg_len_we = 1'b0; m_tready = 1'b1;
    if (!done) fail_to({nm, " pkt"});
    eh = hdr;
    eh[128 +: 16] = exp_len;
`ifdef HDR_CSUM_EN
    eh[192 +: 16] = ref_csum(eh);
`endif
    for (int i = 0; i < HL; i++) lanes.push_back(eh[16*i +: 16]);
    for (int bb = 0; bb < nb; bb++)
      for (int l = 0; l < L; l++)
        if (pk[bb][l]) lanes.push_back(pay[bb][16*l +: 16]);
    nexp = (lanes.size() + L - 1) / L;
    chk({nm, " beats"}, 576'(outq.size()), 576'(nexp));
    for (int i = 0; i < nexp && i < outq.size(); i++) begin
      ed = '0; ek = '0; mask = '0;
      for (int l = 0; l < L; l++)
        if (i*L + l < lanes.size()) begin
          ed[16*l +: 16]   = lanes[i*L + l];
          mask[16*l +: 16] = '1;
          ek[l]            = 1'b1;
        end
      chk($sformatf("%s b%0d keep", nm, i), 576'(outq[i].keep), 576'(ek));
      chk($sformatf("%s b%0d last", nm, i), 576'(outq[i].last), 576'(i == nexp-1));
      chk($sformatf("%s b%0d data", nm, i), 576'(outq[i].data & mask), 576'(ed));
    end
    nout = outq.size();
    if (nout > 0) okeep = outq[nout-1].keep;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    logic [HB-1:0] h;
    logic [L-1:0]  okeep;
    logic [15:0]   words[10];
    int nout, lat, k, t;

    vecs[0] = '{1, 32'h0000_7FFF, 1, 32'hFFFF_FFFF};
    vecs[1] = '{1, 32'hFFFF_FFFF, 2, 32'h0001_FFFF};
    vecs[2] = '{2, 32'h0000_0001, 2, 32'h0003_FFFF};
    vecs[3] = '{3, 32'h0000_FFFF, 4, 32'h0000_0001};
    vecs[4] = '{1, 32'h0000_FFFF, 2, 32'h0000_0001};
    vecs[5] = '{2, 32'h0000_7FFF, 2, 32'hFFFF_FFFF};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst m_tvalid",  576'(m_tvalid),  576'(0));
    chk("rst s_tready",  576'(s_tready),  576'(0));
    chk("rst hdr_ready", 576'(hdr_ready), 576'(1));
    chk("rst m_tlast",   576'(m_tlast),   576'(0));
    chk("rst m_tkeep",   576'(m_tkeep),   576'(0));
    chk("rst m_tdata",   576'(m_tdata),   576'(0));
    @(negedge clk);
    rst = 1'b1;
    step();
    cfg_len = 16'h0055; cfg_len_we = 1'b1;
    step();
    cfg_len_we = 1'b0;

    // Single/multi-beat shapes with hand-computed beat counts and final keep
    foreach (vecs[i]) begin
      run_pkt($sformatf("vec%0d", i), rnd_hdr(), vecs[i].nb, vecs[i].lkeep, 1'b0,
              16'h0055, -1, 16'h0055, nout, okeep, lat);
      chk($sformatf("vec%0d nout", i),  576'(nout),  576'(vecs[i].exp_n));
      chk($sformatf("vec%0d lkeep", i), 576'(okeep), 576'(vecs[i].exp_k));
    end

    // 4-beat packet under alternating m_tready (hold checked in step)
    run_pkt("alt4", rnd_hdr(), 4, 32'h0000_00FF, 1'b1, 16'h0055, -1, 16'h0055,
            nout, okeep, lat);
    chk("alt4 nout",  576'(nout),  576'(4));
    chk("alt4 lkeep", 576'(okeep), 576'(32'h01FF_FFFF));

    // Known IPv4 header window; field slot carries 0x1234 in the template
    cfg_len = 16'h0073; cfg_len_we = 1'b1;
    step();
    cfg_len_we = 1'b0;
    words = '{16'h4500, 16'h0073, 16'h0000, 16'h4000, 16'h4011,
              16'h1234, 16'hc0a8, 16'h0001, 16'hc0a8, 16'h00c7};
    h = rnd_hdr();
    for (int i = 0; i < 10; i++) h[112 + 16*i +: 16] = words[i];
    h[128 +: 16] = 16'hDEAD;  // overwritten by the length register
    run_pkt("ipv4", h, 1, 32'h0000_7FFF, 1'b0, 16'h0073, -1, 16'h0073, nout, okeep, lat);
    if (nout > 0) begin
      chk("ipv4 csum field", 576'(outq[0].data[192 +: 16]), 576'(EXP_T4_FIELD));
      chk("ipv4 len field",  576'(outq[0].data[128 +: 16]), 576'(16'h0073));
    end else fail_to("ipv4 no output");
    chk("ipv4 csum latency", 576'(lat), 576'(EXP_LAT));

    // Length written mid-packet applies only to the following header
    run_pkt("len_a", rnd_hdr(), 3, 32'hFFFF_FFFF, 1'b0, 16'h0073, 2, 16'h0100,
            nout, okeep, lat);
    run_pkt("len_b", rnd_hdr(), 1, 32'h0000_0003, 1'b0, 16'h0100, -1, 16'h0100,
            nout, okeep, lat);
    if (nout > 0) chk("len_b field", 576'(outq[0].data[128 +: 16]), 576'(16'h0100));
    else fail_to("len_b no output");

    // Reset while in BODY drops the packet
    hdr_in = rnd_hdr(); hdr_valid = 1'b1; m_tready = 1'b1;
    t = 0;
    do begin step(); t++; end while (!hdr_fire && t < 50);
    hdr_valid = 1'b0;
    if (!hdr_fire) fail_to("rstbody hdr");
    s_tvalid = 1'b1; s_tkeep = '1; s_tlast = 1'b0; s_tdata = rnd512();
    k = 0; t = 0;
    while (k < 2 && t < 50) begin
      step();
      if (in_fire) begin k++; s_tdata = rnd512(); end
      t++;
    end
    if (k < 2) fail_to("rstbody beats");
    rst = 1'b0; s_tvalid = 1'b0;
    step();
    #1;
    chk("rstbody m_tvalid",  576'(m_tvalid),  576'(0));
    chk("rstbody s_tready",  576'(s_tready),  576'(0));
    chk("rstbody hdr_ready", 576'(hdr_ready), 576'(1));
    rst = 1'b1;
    step();
    run_pkt("postrst", rnd_hdr(), 2, 32'h0001_FFFF, 1'b0, 16'h0000, -1, 16'h0000,
            nout, okeep, lat);
    chk("postrst nout",  576'(nout),  576'(3));
    chk("postrst lkeep", 576'(okeep), 576'(32'h0000_0003));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
